uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx serialiser among NUM_REQ byte-stream requesters.
//  - Round-robin arbitration at message granularity.
//  - A granted requester keeps the line until it marks a byte req_last or hits MAX_BURST bytes.
//  - Sits between per-function byte sources (cmd echo, status, debug) and the single uart_tx instance.
// PARAMETERS
//  NUM_REQ    4   number of requesters (2..8)
//  MAX_BURST  16  max bytes per grant before forced rotation (1..255)
//  START_TMO  4   cycles to wait for tx_busy to rise after tx_en before flagging tx_err
// PORTS
//  clk         in   1          system clock
//  reset       in   1          synchronous, active-high reset
//  req_valid   in   NUM_REQ    requester i has a byte on req_data[8*i+:8]
//  req_data    in   8*NUM_REQ  byte per requester
//  req_last    in   NUM_REQ    byte is the last of the message
//  req_ready   out  NUM_REQ    one-cycle accept pulse; byte consumed when valid&ready
//  tx_en       out  1          one-cycle pulse to uart_tx: load tx_data
//  tx_data     out  8          byte to uart_tx, held stable from tx_en until tx_busy falls
//  tx_busy     in   1          uart_tx serialising; rises the cycle after tx_en
//  grant       out  NUM_REQ    one-hot owner of the line, zero when idle
//  tx_err      out  1          sticky: tx_busy failed to rise within START_TMO; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; rr_ptr=0; burst_cnt=0. Reset mid-byte abandons the byte, with no req_ready.
//  States: IDLE, ISSUE, WAIT_START, WAIT_DONE, HOLD.
//  IDLE
//   - If any req_valid and !tx_busy: pick the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
//   - Set grant; burst_cnt=0; go to ISSUE next cycle.
//  ISSUE (1 cycle)
//   - tx_en=1; tx_data=req_data[g]; req_ready[g]=1.
//   - Latch req_last into last_q; burst_cnt++; go to WAIT_START.
//  WAIT_START
//   - On tx_busy=1 go to WAIT_DONE.
//   - After START_TMO cycles without it: set tx_err, clear grant, rr_ptr=g+1, go to IDLE.
//  WAIT_DONE: on tx_busy=0,
//   - If last_q or burst_cnt==MAX_BURST: clear grant, rr_ptr=g+1 (wrap), go to IDLE.
//   - Otherwise go to HOLD.
//  HOLD
//   - If req_valid[g]: go to ISSUE.
//   - Other requests are ignored; the owner holds the line until last/MAX_BURST.
//  Latency
//   - Requester valid to tx_en: 2 cycles from IDLE (arbitrate, ISSUE).
//   - Back-to-back in-message bytes: tx_en 1 cycle after HOLD sees req_valid[g].
//  Fairness
//   - rr_ptr advances only on grant release.
//   - A requester asserting valid every message gets the line once per NUM_REQ releases.
//  Boundaries
//   - Simultaneous valid on all inputs: lowest index >= rr_ptr wins.
//   - rr_ptr wraps from NUM_REQ-1 to 0.
//   - req_last with burst_cnt==MAX_BURST releases once, with no double advance.
//   - req_valid dropping in HOLD: remain in HOLD, with no timeout.
//   - tx_busy already high in IDLE: no arbitration until it is low.
//   - req_ready is never asserted to a non-granted requester.
//   - At most one req_ready bit is high per cycle.
// TESTING (bench models uart_tx: tx_busy high 1 cycle after tx_en for 10 cycles)
//  - Single message: req0 sends 0x41,0x42(last).
//    -> tx_en twice, tx_data 0x41 then 0x42; grant=0001 then 0000; rr_ptr=1.
//  - Contention: req0..3 all valid, 1-byte last messages, rr_ptr=0.
//    -> service order 0,1,2,3,0; one grant bit at a time.
//  - Burst cap: MAX_BURST=16; req2 streams 20 bytes, no last, req1 waiting.
//    -> 16 bytes from req2, then req1's message, then req2 resumes.
//  - No interleave: req1 mid-message stalls 50 cycles in HOLD while req3 is valid.
//    -> grant stays 0010; req3 is not served until req1's last byte.
//  - Timeout: tie tx_busy=0.
//    -> tx_err=1 exactly START_TMO cycles after tx_en; grant cleared; next requester served.
//  - Reset mid-byte: assert reset in WAIT_DONE.
//    -> next cycle all outputs 0, state IDLE; after release, arbitration restarts at req0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serialiser among NUM_REQ byte streams.
// Ownership is per message: the owner keeps the line until req_last or MAX_BURST bytes.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,   // 2..8
    parameter int MAX_BURST = 16,  // 1..255
    parameter int START_TMO = 4    // 2..255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   tx_err,
    output logic [2:0]             dbg_state
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_HOLD       = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [7:0]         burst_q, burst_d;
    logic               last_q, last_d;
    logic [7:0]         tmo_q, tmo_d;
    logic [7:0]         data_q, data_d;
    logic               err_q, err_d;

    logic [IW:0]        cand;
    logic [IW-1:0]      pick_idx;
    logic               pick_found;
    logic [IW-1:0]      next_ptr;
    logic [7:0]         cur_byte;

    // First valid requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        cand       = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!pick_found && req_valid[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gidx_q == IW'(k)) begin
                cur_byte = req_data[8*k +: 8];
            end
        end
    end

    assign next_ptr = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);

    // Handshake: a requester holds req_valid/req_data/req_last stable until it
    // sees req_ready; the byte is consumed on the cycle where valid & ready.
    // req_ready is a single-cycle pulse in ISSUE, only to the granted index.
    assign tx_en     = (state_q == S_ISSUE);
    assign req_ready = tx_en ? grant_q : '0;
    assign tx_data   = tx_en ? cur_byte : data_q;
    assign grant     = grant_q;
    assign tx_err    = err_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found && !tx_busy) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    gidx_d            = pick_idx;
                    burst_d           = '0;
                    state_d           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                data_d  = cur_byte;
                last_d  = req_last[gidx_q];
                burst_d = burst_q + 8'd1;
                // The ISSUE cycle counts as the first cycle of the start window.
                tmo_d   = 8'd1;
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q >= 8'(START_TMO - 1)) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    rr_d    = next_ptr;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q || (burst_q == 8'(MAX_BURST))) begin
                        grant_d = '0;
                        rr_d    = next_ptr;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // No timeout here: the owner may pause mid-message indefinitely.
                if (req_valid[gidx_q]) begin
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            burst_q <= '0;
            last_q  <= 1'b0;
            tmo_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));
    a_ready_granted: assert property (@(posedge clk) disable iff (reset) (req_ready & ~grant_q) == '0);
    a_en_has_owner: assert property (@(posedge clk) disable iff (reset) tx_en |-> (grant_q != '0));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: byte sources per requester, a uart_tx
// busy model, and a scoreboard of expected {grant, tx_data} per tx_en pulse.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 16;
    localparam int START_TMO = 4;
    localparam int W         = NUM_REQ + 8;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_HOLD      = 3'd4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_en;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_err;
    logic [2:0]           dbg_state;

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_BURST(MAX_BURST),
        .START_TMO(START_TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .grant    (grant),
        .tx_err   (tx_err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- uart_tx model ----------------
    // busy rises the cycle after tx_en and stays high for 10 cycles.
    int  busy_cnt  = 0;
    bit  en_seen   = 1'b0;
    bit  busy_dead = 1'b0;
    assign tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (en_seen) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    logic [7:0]   last_data = 8'h00;
    int           last_en_cyc = 0;

    task automatic push_exp(input int i, input logic [7:0] d);
        logic [NUM_REQ-1:0] g;
        g    = '0;
        g[i] = 1'b1;
        exp_q.push_back({g, d});
    endtask

    always @(negedge clk) begin
        en_seen = tx_en && !busy_dead;
        if (!reset) begin
            if (tx_en) begin
                check_eq("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    check_eq("tx_grant_data", 32'({grant, tx_data}), 32'(exp_v));
                    last_data = exp_v[7:0];
                end
                check_eq("ready_eq_grant", 32'(req_ready), 32'(grant));
                last_en_cyc = cyc;
            end
            if (req_ready != '0) check_eq("ready_subset", 32'(req_ready & ~grant), 32'd0);
            if (dbg_state == S_WAIT_DONE) check_eq("tx_data_hold", 32'(tx_data), 32'(last_data));
        end
    end

    // ---------------- requester drivers ----------------
    logic [8:0] src_mem [NUM_REQ][32];
    int         src_len [NUM_REQ];
    int         src_pos [NUM_REQ];
    int         hold_at [NUM_REQ];

    task automatic clear_sources();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
            hold_at[i] = -1;
        end
    endtask

    task automatic add_byte(input int i, input logic [7:0] d, input logic last);
        src_mem[i][src_len[i]] = {last, d};
        src_len[i]++;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_pos[i] < src_len[i] && src_pos[i] != hold_at[i]) begin
                req_valid[i]        = 1'b1;
                req_last[i]         = src_mem[i][src_pos[i]][8];
                req_data[8*i +: 8]  = src_mem[i][src_pos[i]][7:0];
            end else begin
                req_valid[i]        = 1'b0;
                req_last[i]         = 1'b0;
                req_data[8*i +: 8]  = 8'h00;
            end
        end
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) if (acc[i]) src_pos[i]++;
        drive_inputs();
    endtask

    function automatic bit all_sent();
        for (int i = 0; i < NUM_REQ; i++) if (src_pos[i] < src_len[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until_done(input int budget);
        int n = 0;
        while (n < budget && !(exp_q.size() == 0 && all_sent() && dbg_state == S_IDLE && !tx_busy)) begin
            step();
            n++;
        end
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_sources();
        exp_q.delete();
        drive_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit got_err;
        int n;

        reset = 1'b1;
        clear_sources();
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_tx_en", 32'(tx_en), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_tx_err", 32'(tx_err), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(S_IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single message from req0.
        add_byte(0, 8'h41, 1'b0);
        add_byte(0, 8'h42, 1'b1);
        push_exp(0, 8'h41);
        push_exp(0, 8'h42);
        drive_inputs();
        run_until_done(200);
        check_eq("single_grant_idle", 32'(grant), 32'd0);

        // Contention with rr_ptr left at 1: order 1,2,3,0.
        for (int i = 0; i < NUM_REQ; i++) add_byte(i, 8'hA0 + 8'(i), 1'b1);
        for (int k = 1; k <= NUM_REQ; k++) push_exp(k % NUM_REQ, 8'hA0 + 8'(k % NUM_REQ));
        drive_inputs();
        run_until_done(400);

        // Contention from reset: two one-byte messages each, order 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            add_byte(i, 8'hB0 + 8'(i), 1'b1);
            add_byte(i, 8'hC0 + 8'(i), 1'b1);
        end
        for (int i = 0; i < NUM_REQ; i++) push_exp(i, 8'hB0 + 8'(i));
        for (int i = 0; i < NUM_REQ; i++) push_exp(i, 8'hC0 + 8'(i));
        drive_inputs();
        run_until_done(800);

        // Burst cap: req2 streams 20 bytes, req1 waits; 16 from req2, req1, then req2 resumes.
        do_reset();
        for (int k = 0; k < 20; k++) add_byte(2, 8'h20 + 8'(k), (k == 19));
        add_byte(1, 8'h71, 1'b0);
        add_byte(1, 8'h72, 1'b1);
        hold_at[1] = 0;
        for (int k = 0; k < MAX_BURST; k++) push_exp(2, 8'h20 + 8'(k));
        push_exp(1, 8'h71);
        push_exp(1, 8'h72);
        for (int k = MAX_BURST; k < 20; k++) push_exp(2, 8'h20 + 8'(k));
        drive_inputs();
        repeat (5) step();
        hold_at[1] = -1;
        run_until_done(2000);

        // No interleave: req1 stalls mid-message while req3 is valid.
        do_reset();
        add_byte(1, 8'h91, 1'b0);
        add_byte(1, 8'h92, 1'b0);
        add_byte(1, 8'h93, 1'b1);
        add_byte(3, 8'hD3, 1'b1);
        hold_at[1] = 1;
        push_exp(1, 8'h91);
        push_exp(1, 8'h92);
        push_exp(1, 8'h93);
        push_exp(3, 8'hD3);
        drive_inputs();
        repeat (65) step();
        check_eq("hold_grant", 32'(grant), 32'h2);
        check_eq("hold_state", 32'(dbg_state), 32'(S_HOLD));
        check_eq("hold_no_err", 32'(tx_err), 32'd0);
        check_eq("hold_req3_waiting", 32'(src_pos[3]), 32'd0);
        hold_at[1] = -1;
        run_until_done(400);

        // Start timeout: uart_tx never goes busy.
        do_reset();
        busy_dead = 1'b1;
        add_byte(0, 8'h55, 1'b1);
        add_byte(1, 8'h66, 1'b1);
        push_exp(0, 8'h55);
        push_exp(1, 8'h66);
        drive_inputs();
        got_err = 1'b0;
        n = 0;
        while (n < 40 && !got_err) begin
            step();
            if (tx_err) got_err = 1'b1;
            n++;
        end
        check_eq("tmo_err_seen", 32'(got_err), 32'd1);
        check_eq("tmo_latency", 32'(cyc - last_en_cyc), 32'(START_TMO));
        check_eq("tmo_grant_clr", 32'(grant), 32'd0);
        run_until_done(200);
        check_eq("tmo_err_sticky", 32'(tx_err), 32'd1);
        busy_dead = 1'b0;

        // Reset in WAIT_DONE, then arbitration restarts at req0 once busy drops.
        do_reset();
        check_eq("rst_clears_err", 32'(tx_err), 32'd0);
        add_byte(2, 8'hE0, 1'b0);
        add_byte(2, 8'hE1, 1'b1);
        push_exp(2, 8'hE0);
        drive_inputs();
        n = 0;
        while (n < 30 && dbg_state != S_WAIT_DONE) begin
            step();
            n++;
        end
        check_eq("reach_wait_done", 32'(dbg_state), 32'(S_WAIT_DONE));
        reset = 1'b1;
        clear_sources();
        drive_inputs();
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_grant", 32'(grant), 32'd0);
        check_eq("mid_rst_tx_en", 32'(tx_en), 32'd0);
        check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
        check_eq("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("busy_after_rst", 32'(tx_busy), 32'd1);
        add_byte(3, 8'hF3, 1'b1);
        add_byte(0, 8'hF0, 1'b1);
        push_exp(0, 8'hF0);
        push_exp(3, 8'hF3);
        drive_inputs();
        n = 0;
        while (n < 20 && tx_busy) begin
            check_eq("no_arb_while_busy", 32'(grant), 32'd0);
            step();
            n++;
        end
        run_until_done(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
